// File: rtl/lif_pkg.sv
// Shared definitions for the LIF layer: sequencer FSM encoding and the default
// datapath widths common to the sequencer and the LIF unit.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    READOUT
  } seq_state_t;

  localparam int MEM_WIDTH   = 24;
  localparam int IN_WIDTH    = 18;
  localparam int COUNT_WIDTH = 4;

endpackage

// File: rtl/lif_state_sequencer_if.sv
// Signal bundle of the LIF state sequencer: current input, LIF unit issue and
// writeback ports, spike-count readout stream and status.
interface lif_state_sequencer_if #(
  parameter int NUM_NEURONS = 16,
  parameter int MEM_WIDTH   = lif_pkg::MEM_WIDTH,
  parameter int IN_WIDTH    = lif_pkg::IN_WIDTH,
  parameter int COUNT_WIDTH = lif_pkg::COUNT_WIDTH
);
  localparam int IDX_W = $clog2(NUM_NEURONS);

  logic                   cur_valid;
  logic                   cur_ready;
  logic [IN_WIDTH-1:0]    cur_data;

  logic                   lif_valid_in;
  logic [IN_WIDTH-1:0]    lif_i_in;
  logic [MEM_WIDTH-1:0]   lif_v_old;
  logic [COUNT_WIDTH-1:0] lif_cnt_old;
  logic                   lif_valid_out;
  logic [MEM_WIDTH-1:0]   lif_v_new;
  logic [COUNT_WIDTH-1:0] lif_cnt_new;

  logic                   step_done;
  logic                   rd_start;
  logic                   cnt_valid;
  logic                   cnt_ready;
  logic [COUNT_WIDTH-1:0] cnt_data;
  logic [IDX_W-1:0]       cnt_idx;
  logic                   cnt_last;
  logic                   busy;

  modport master (
    input  cur_valid, cur_data, lif_valid_out, lif_v_new, lif_cnt_new,
           rd_start, cnt_ready,
    output cur_ready, lif_valid_in, lif_i_in, lif_v_old, lif_cnt_old,
           step_done, cnt_valid, cnt_data, cnt_idx, cnt_last, busy
  );

  modport slave (
    output cur_valid, cur_data, lif_valid_out, lif_v_new, lif_cnt_new,
           rd_start, cnt_ready,
    input  cur_ready, lif_valid_in, lif_i_in, lif_v_old, lif_cnt_old,
           step_done, cnt_valid, cnt_data, cnt_idx, cnt_last, busy
  );

endinterface

// File: rtl/lif_wb_delay.sv
// Delay line carrying the issued neuron index alongside the LIF unit pipeline,
// so the index emerges in the same cycle as the unit's result strobe.
module lif_wb_delay #(
  parameter int LIF_LATENCY = 1,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] issue_idx,
  output logic [IDX_W-1:0] wb_idx
);

  logic [LIF_LATENCY*IDX_W-1:0] line;

  generate
    if (LIF_LATENCY == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (!rst_n) line <= '0;
        else        line <= issue_idx;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (!rst_n) line <= '0;
        else        line <= {line[(LIF_LATENCY-1)*IDX_W-1:0], issue_idx};
      end
    end
  endgenerate

  assign wb_idx = line[LIF_LATENCY*IDX_W-1 -: IDX_W];

endmodule

// File: rtl/lif_state_sequencer.sv
// Owns per-neuron membrane and spike-count state, issues one neuron per
// accepted current to the LIF unit, writes results back, and streams counts.
module lif_state_sequencer #(
  parameter int NUM_NEURONS = 16,
  parameter int MEM_WIDTH   = lif_pkg::MEM_WIDTH,
  parameter int IN_WIDTH    = lif_pkg::IN_WIDTH,
  parameter int COUNT_WIDTH = lif_pkg::COUNT_WIDTH,
  parameter int LIF_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lif_state_sequencer_if.master bus
);
  import lif_pkg::*;

  localparam int               IDX_W    = $clog2(NUM_NEURONS);
  localparam int               OUT_W    = $clog2(LIF_LATENCY + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  seq_state_t             state, state_next;
  logic [MEM_WIDTH-1:0]   v_mem [NUM_NEURONS];
  logic [COUNT_WIDTH-1:0] c_mem [NUM_NEURONS];
  logic [IDX_W-1:0]       k, issue_idx, wb_idx;
  logic [OUT_W-1:0]       outstanding;
  logic                   cur_fire, rd_fire, cnt_fire, wb_en, drain_done;

  always_comb begin
    state_next    = state;
    cur_fire      = 1'b0;
    rd_fire       = 1'b0;
    drain_done    = 1'b0;
    bus.cur_ready = 1'b0;
    cnt_fire      = (state == READOUT) && bus.cnt_valid && bus.cnt_ready;
    case (state)
      IDLE: begin
        bus.cur_ready = !bus.rd_start;
        if (bus.rd_start) begin
          rd_fire    = 1'b1;
          state_next = READOUT;
        end else if (bus.cur_valid) begin
          cur_fire   = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        bus.cur_ready = 1'b1;
        if (bus.cur_valid) begin
          cur_fire = 1'b1;
          if (k == LAST_IDX) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding == '0) begin
          drain_done = 1'b1;
          state_next = IDLE;
        end
      end
      READOUT: begin
        if (cnt_fire && bus.cnt_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);
  assign wb_en    = bus.lif_valid_out && (outstanding != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  lif_wb_delay #(
    .LIF_LATENCY (LIF_LATENCY),
    .IDX_W       (IDX_W)
  ) u_wb_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue_idx (issue_idx),
    .wb_idx    (wb_idx)
  );

  // Outstanding counts from acceptance rather than from lif_valid_in, so a
  // final gapped current cannot let DRAIN see zero before its issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k                <= '0;
      issue_idx        <= '0;
      outstanding      <= '0;
      bus.lif_valid_in <= 1'b0;
      bus.lif_i_in     <= '0;
      bus.lif_v_old    <= '0;
      bus.lif_cnt_old  <= '0;
      bus.step_done    <= 1'b0;
      bus.cnt_valid    <= 1'b0;
      bus.cnt_data     <= '0;
      bus.cnt_idx      <= '0;
      bus.cnt_last     <= 1'b0;
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        v_mem[i] <= '0;
        c_mem[i] <= '0;
      end
    end else begin
      bus.lif_valid_in <= cur_fire;
      bus.step_done    <= drain_done;
      outstanding      <= outstanding + OUT_W'(cur_fire) - OUT_W'(wb_en);

      if (cur_fire) begin
        bus.lif_i_in    <= IN_WIDTH'(bus.cur_data);
        bus.lif_v_old   <= v_mem[k];
        bus.lif_cnt_old <= c_mem[k];
        issue_idx       <= k;
        k               <= (k == LAST_IDX) ? '0 : k + 1'b1;
      end

      if (wb_en) begin
        v_mem[wb_idx] <= bus.lif_v_new;
        c_mem[wb_idx] <= bus.lif_cnt_new;
      end

      if (rd_fire) begin
        bus.cnt_valid <= 1'b1;
        bus.cnt_data  <= c_mem[0];
        bus.cnt_idx   <= '0;
        bus.cnt_last  <= 1'b0;
      end else if (cnt_fire) begin
        v_mem[bus.cnt_idx] <= '0;
        c_mem[bus.cnt_idx] <= '0;
        if (bus.cnt_last) begin
          bus.cnt_valid <= 1'b0;
          bus.cnt_data  <= '0;
          bus.cnt_idx   <= '0;
          bus.cnt_last  <= 1'b0;
        end else begin
          bus.cnt_data  <= c_mem[bus.cnt_idx + 1'b1];
          bus.cnt_idx   <= bus.cnt_idx + 1'b1;
          bus.cnt_last  <= ((bus.cnt_idx + 1'b1) == LAST_IDX);
        end
      end
    end
  end

endmodule
